grey_sweep_ctrl: RTL and testbench

Sequencer for the 5-bit binary-to-Grey converter. It sweeps a programmable binary range up or down, feeds each count through the converter, and presents binary/Grey pairs on a valid/ready stream. It sits between test or control logic and any Grey-consuming downstream block, such as an encoder model or an async-FIFO pointer checker. It also monitors every non-wrap step for the single-bit-change property.

---
 rtl/grey_pkg.sv | 18 +
 rtl/bin_to_grey.sv | 21 ++
 rtl/grey_sweep_ctrl.sv | 143 ++++++++++++++
 tb/tb_grey_sweep_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/grey_pkg.sv
// Shared types and helpers for the Grey sweep sequencer.
package grey_pkg;

    localparam int GREY_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [GREY_W-1:0] bin2grey(
        input logic [GREY_W-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/bin_to_grey.sv
// 5-bit binary to Grey converter, scalar bit ports.
module bin_to_grey (
    input  logic b4,
    input  logic b3,
    input  logic b2,
    input  logic b1,
    input  logic b0,
    output logic g4,
    output logic g3,
    output logic g2,
    output logic g1,
    output logic g0
);

    assign g4 = b4;
    assign g3 = b4 ^ b3;
    assign g2 = b3 ^ b2;
    assign g1 = b2 ^ b1;
    assign g0 = b1 ^ b0;

endmodule

// File: rtl/grey_sweep_ctrl.sv
// Sweeps a binary range, streams binary/Grey pairs and checks
// that every non-wrap step flips exactly one Grey bit.
module grey_sweep_ctrl
    import grey_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [GREY_W-1:0] lo,
    input  logic [GREY_W-1:0] hi,
    input  logic              dir,
    input  logic              mode,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [GREY_W-1:0] bin_out,
    output logic [GREY_W-1:0] grey_out,
    output logic              busy,
    output logic              done,
    output logic              err_range,
    output logic              err_adj,
    output logic [CNT_W-1:0]  xfer_cnt
);

    state_t            state;
    logic [GREY_W-1:0] lo_q;
    logic [GREY_W-1:0] hi_q;
    logic              dir_q;
    logic              mode_q;
    logic [GREY_W-1:0] prev_grey;
    logic              have_prev;
    logic              skip;

    logic [GREY_W-1:0] first_v;
    logic [GREY_W-1:0] last_v;
    logic [GREY_W-1:0] nxt;
    logic [GREY_W-1:0] nxt_g;
    logic              at_end;
    logic              xfer;

    always_comb begin
        first_v = dir_q ? hi_q : lo_q;
        last_v  = dir_q ? lo_q : hi_q;
        at_end  = (bin_out == last_v);
        xfer    = out_valid & out_ready;
        nxt     = bin_out;
        if (state == IDLE)
            nxt = dir ? hi : lo;
        else if (at_end)
            nxt = first_v;
        else if (dir_q)
            nxt = bin_out - GREY_W'(1);
        else
            nxt = bin_out + GREY_W'(1);
    end

    bin_to_grey u_conv (
        .b4 (nxt[4]),
        .b3 (nxt[3]),
        .b2 (nxt[2]),
        .b1 (nxt[1]),
        .b0 (nxt[0]),
        .g4 (nxt_g[4]),
        .g3 (nxt_g[3]),
        .g2 (nxt_g[2]),
        .g1 (nxt_g[1]),
        .g0 (nxt_g[0])
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lo_q      <= '0;
            hi_q      <= '0;
            dir_q     <= 1'b0;
            mode_q    <= 1'b0;
            prev_grey <= '0;
            have_prev <= 1'b0;
            skip      <= 1'b0;
            out_valid <= 1'b0;
            bin_out   <= '0;
            grey_out  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_range <= 1'b0;
            err_adj   <= 1'b0;
            xfer_cnt  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (lo > hi) begin
                            err_range <= 1'b1;
                        end else begin
                            lo_q      <= lo;
                            hi_q      <= hi;
                            dir_q     <= dir;
                            mode_q    <= mode;
                            bin_out   <= nxt;
                            grey_out  <= nxt_g;
                            out_valid <= 1'b1;
                            busy      <= 1'b1;
                            xfer_cnt  <= '0;
                            err_adj   <= 1'b0;
                            have_prev <= 1'b0;
                            skip      <= 1'b0;
                            state     <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (xfer) begin
                        if (xfer_cnt != '1)
                            xfer_cnt <= xfer_cnt + CNT_W'(1);
                        // reference grey from the package, not the converter
                        if (have_prev && !skip &&
                            $countones(prev_grey ^ grey_out) != 1)
                            err_adj <= 1'b1;
                        prev_grey <= bin2grey(bin_out);
                        have_prev <= 1'b1;
                        skip      <= at_end;
                        if (!at_end || mode_q) begin
                            bin_out  <= nxt;
                            grey_out <= nxt_g;
                        end
                    end
                    if (stop || (xfer && at_end && !mode_q)) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_grey_sweep_ctrl.sv
// Scoreboard bench for grey_sweep_ctrl.
module tb_grey_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic [4:0] lo;
    logic [4:0] hi;
    logic       dir;
    logic       mode;
    logic       out_ready;
    logic       out_valid;
    logic [4:0] bin_out;
    logic [4:0] grey_out;
    logic       busy;
    logic       done;
    logic       err_range;
    logic       err_adj;
    logic [7:0] xfer_cnt;

    grey_sweep_ctrl #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .lo        (lo),
        .hi        (hi),
        .dir       (dir),
        .mode      (mode),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .bin_out   (bin_out),
        .grey_out  (grey_out),
        .busy      (busy),
        .done      (done),
        .err_range (err_range),
        .err_adj   (err_adj),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] GT [32] = '{
        5'h00, 5'h01, 5'h03, 5'h02, 5'h06, 5'h07, 5'h05, 5'h04,
        5'h0C, 5'h0D, 5'h0F, 5'h0E, 5'h0A, 5'h0B, 5'h09, 5'h08,
        5'h18, 5'h19, 5'h1B, 5'h1A, 5'h1E, 5'h1F, 5'h1D, 5'h1C,
        5'h14, 5'h15, 5'h17, 5'h16, 5'h12, 5'h13, 5'h11, 5'h10
    };

    int         checks = 0;
    int         errors = 0;
    logic [9:0] exp_q [$];
    logic       bp = 1'b0;
    int         bp_ph = 0;
    logic       hold_pending = 1'b0;
    logic [4:0] hold_b;
    logic [4:0] hold_g;

    task automatic chk(input string name, input int act,
                       input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d",
                     name, act, exp);
        end
    endtask

    task automatic push(input int b, input logic [4:0] g);
        exp_q.push_back({5'(b), g});
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [9:0] e;
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                chk("hold_bin", bin_out, hold_b);
                chk("hold_grey", grey_out, hold_g);
            end
            hold_pending = out_valid && !out_ready;
            hold_b = bin_out;
            hold_g = grey_out;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_xfer: got bin %0d expected none",
                             bin_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("bin", bin_out, e[9:5]);
                    chk("grey", grey_out, e[4:0]);
                end
            end
        end
    end

    // backpressure pattern 1,0,0,...
    always @(posedge clk) begin
        #1;
        if (bp) begin
            out_ready = (bp_ph % 3 == 0);
            bp_ph++;
        end
    end

    task automatic start_sweep(input logic [4:0] l,
                               input logic [4:0] h,
                               input logic d, input logic m);
        @(posedge clk);
        #1;
        lo = l;
        hi = h;
        dir = d;
        mode = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lo = 5'd31;
        hi = 5'd0;
        dir = ~d;
        mode = ~m;
    endtask

    task automatic wait_done(input string name, input int budget,
                             input int exp_x);
        bit found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s_done_timeout: got no done expected done", name);
        end else begin
            chk({name, "_xfer_cnt"}, xfer_cnt, exp_x);
            chk({name, "_valid_in_done"}, out_valid, 0);
            chk({name, "_busy_in_done"}, busy, 0);
            chk({name, "_sb_empty"}, exp_q.size(), 0);
            @(negedge clk);
            chk({name, "_done_one_cycle"}, done, 0);
        end
    endtask

    task automatic check_zero(input string name);
        chk({name, "_valid"}, out_valid, 0);
        chk({name, "_bin"}, bin_out, 0);
        chk({name, "_grey"}, grey_out, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_err_range"}, err_range, 0);
        chk({name, "_err_adj"}, err_adj, 0);
        chk({name, "_xfer_cnt"}, xfer_cnt, 0);
    endtask

    initial begin
        int seen;
        bit hit;
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        lo = '0;
        hi = '0;
        dir = 1'b0;
        mode = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_zero("reset");

        for (int i = 0; i < 32; i++) push(i, GT[i]);
        start_sweep(5'd0, 5'd31, 1'b0, 1'b0);
        wait_done("up_full", 40, 32);
        chk("up_err_adj", err_adj, 0);
        chk("up_err_range", err_range, 0);

        push(5, 5'b00111);
        push(4, 5'b00110);
        push(3, 5'b00010);
        push(2, 5'b00011);
        start_sweep(5'd2, 5'd5, 1'b1, 1'b0);
        wait_done("down", 10, 4);

        bp_ph = 0;
        bp = 1'b1;
        for (int i = 3; i <= 6; i++) push(i, GT[i]);
        start_sweep(5'd3, 5'd6, 1'b0, 1'b0);
        wait_done("bp", 30, 4);
        bp = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;

        push(28, GT[28]);
        push(29, GT[29]);
        push(30, GT[30]);
        push(31, GT[31]);
        push(28, GT[28]);
        push(29, GT[29]);
        start_sweep(5'd28, 5'd31, 1'b0, 1'b1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid && out_ready && bin_out == 5'd29)
                seen++;
            if (seen == 2) break;
        end
        chk("wrap_second_29_seen", seen, 2);
        stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        wait_done("wrap_stop", 5, 6);
        chk("wrap_err_adj", err_adj, 0);

        @(posedge clk);
        #1;
        lo = 5'd9;
        hi = 5'd4;
        dir = 1'b0;
        mode = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("range_err", err_range, 1);
        chk("range_valid", out_valid, 0);
        chk("range_busy", busy, 0);
        repeat (2) @(negedge clk);
        chk("range_idle_valid", out_valid, 0);

        push(10, GT[10]);
        push(11, GT[11]);
        push(12, GT[12]);
        start_sweep(5'd10, 5'd20, 1'b0, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid && bin_out == 5'd12) begin
                hit = 1'b1;
                break;
            end
        end
        chk("rst_reached_12", hit, 1);
        chk("range_err_sticky", err_range, 1);
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_zero("mid_rst");
        chk("mid_rst_sb_empty", exp_q.size(), 0);
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_no_done", done, 0);
        end

        push(7, GT[7]);
        start_sweep(5'd7, 5'd7, 1'b1, 1'b0);
        wait_done("single", 10, 1);
        chk("single_err_adj", err_adj, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
